// File: rtl/fp32_pkg.sv
// fp32_pkg: shared float32 field constants, canonical values, a NaN test and
// the state encodings used by dot_accumulator and its adder.
//
// Contents:
//   FP32_SIGN_BIT / FP32_EXP_MSB / FP32_EXP_LSB / FP32_MANT_MSB  field positions
//   FP32_EXP_ALL1   exponent field value for inf/NaN
//   FP32_CANON_NAN  canonical quiet NaN, FP32_ZERO  positive zero
//   fp32_isnan()    exponent all ones with a nonzero mantissa
//   acc_state_t     dot_accumulator FSM states
//   add_state_t     adder FSM states
package fp32_pkg;

    localparam int FP32_SIGN_BIT = 31;
    localparam int FP32_EXP_MSB  = 30;
    localparam int FP32_EXP_LSB  = 23;
    localparam int FP32_MANT_MSB = 22;

    localparam logic [7:0]  FP32_EXP_ALL1  = 8'hFF;
    localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_ZERO      = 32'h0000_0000;

    function automatic logic fp32_isnan(input logic [31:0] v);
        return (v[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALL1) &&
               (v[FP32_MANT_MSB:0] != 23'd0);
    endfunction

    typedef enum logic [2:0] {
        GET_FIRST = 3'd0,
        GET_NEXT  = 3'd1,
        ADD_REQ   = 3'd2,
        ADD_WAIT  = 3'd3,
        PUT_Z     = 3'd4
    } acc_state_t;

    typedef enum logic [1:0] {
        ADD_GET_A = 2'd0,
        ADD_GET_B = 2'd1,
        ADD_CALC  = 2'd2,
        ADD_PUT_Z = 2'd3
    } add_state_t;

endpackage

// File: rtl/adder.sv
// adder: float32 adder with stb/ack handshakes on both operands and the result.
// Operand A is taken first, then B; the sum is computed in one cycle and held
// on output_z until the consumer acks. Round-to-nearest-even, subnormals
// supported, any NaN operand or inf+(-inf) yields the canonical quiet NaN.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   input_a, input_a_stb/ack    operand A and its handshake
//   input_b, input_b_stb/ack    operand B and its handshake
//   output_z, output_z_stb/ack  sum and its handshake
module adder
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    add_state_t  state, state_nxt;
    logic [31:0] a, b, z;

    // datapath intermediates
    logic        swap, sx, sy;
    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [26:0] mx_ext, my_ext, my_sh;
    logic [27:0] sum28;
    logic [4:0]  lz;
    logic [9:0]  e, limit, sh, en;
    logic [26:0] mn;
    logic        up;
    logic [24:0] rm;
    logic [23:0] rm_m;
    logic [31:0] res;

    always_comb begin
        swap   = b[FP32_EXP_MSB:0] > a[FP32_EXP_MSB:0];
        x      = swap ? b : a;
        y      = swap ? a : b;
        sx     = x[FP32_SIGN_BIT];
        sy     = y[FP32_SIGN_BIT];
        // subnormals use exponent 1 with no hidden bit
        ex     = (x[FP32_EXP_MSB:FP32_EXP_LSB] == 8'd0) ? 8'd1 : x[FP32_EXP_MSB:FP32_EXP_LSB];
        ey     = (y[FP32_EXP_MSB:FP32_EXP_LSB] == 8'd0) ? 8'd1 : y[FP32_EXP_MSB:FP32_EXP_LSB];
        mx     = {x[FP32_EXP_MSB:FP32_EXP_LSB] != 8'd0, x[FP32_MANT_MSB:0]};
        my     = {y[FP32_EXP_MSB:FP32_EXP_LSB] != 8'd0, y[FP32_MANT_MSB:0]};
        d      = ex - ey;
        mx_ext = {mx, 3'b000};
        my_ext = {my, 3'b000};
        // align smaller operand; bits shifted out collapse into the sticky LSB
        if (d >= 8'd27) begin
            my_sh = {26'd0, |my_ext};
        end else begin
            my_sh = (my_ext >> d) | {26'd0, |(my_ext & ((27'd1 << d) - 27'd1))};
        end
        sum28 = (sx == sy) ? ({1'b0, mx_ext} + {1'b0, my_sh})
                           : ({1'b0, mx_ext} - {1'b0, my_sh});
        e     = {2'b00, ex};
        limit = e - 10'd1;
        lz    = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum28[i]) lz = 5'(26 - i);
        end
        if (sum28[27]) begin
            mn = {sum28[27:2], sum28[1] | sum28[0]};
            sh = 10'd0;
            en = e + 10'd1;
        end else begin
            // normalise left, but never below exponent 1 (subnormal result)
            sh = ({5'd0, lz} < limit) ? {5'd0, lz} : limit;
            mn = sum28[26:0] << sh;
            en = e - sh;
        end
        up = mn[2] & (mn[1] | mn[0] | mn[3]);
        rm = {1'b0, mn[26:3]} + {24'd0, up};
        rm_m = rm[23:0];
        if (rm[24]) begin
            rm_m = rm[24:1];
            en   = en + 10'd1;
        end
        if (en >= 10'd255) begin
            res = {sx, FP32_EXP_ALL1, 23'd0};
        end else begin
            res = {sx, (rm_m[23] ? en[7:0] : 8'd0), rm_m[FP32_MANT_MSB:0]};
        end
        if (sum28 == 28'd0) res = {sx & sy, 31'd0};
        // special operands override the arithmetic path
        if (fp32_isnan(a) || fp32_isnan(b)) begin
            res = FP32_CANON_NAN;
        end else if (a[FP32_EXP_MSB:0] == {FP32_EXP_ALL1, 23'd0}) begin
            if (b[FP32_EXP_MSB:0] == {FP32_EXP_ALL1, 23'd0} &&
                a[FP32_SIGN_BIT] != b[FP32_SIGN_BIT]) begin
                res = FP32_CANON_NAN;
            end else begin
                res = a;
            end
        end else if (b[FP32_EXP_MSB:0] == {FP32_EXP_ALL1, 23'd0}) begin
            res = b;
        end
    end

    always_comb begin
        state_nxt    = state;
        input_a_ack  = 1'b0;
        input_b_ack  = 1'b0;
        output_z_stb = 1'b0;
        output_z     = z;
        case (state)
            ADD_GET_A: begin
                input_a_ack = 1'b1;
                if (input_a_stb) state_nxt = ADD_GET_B;
            end
            ADD_GET_B: begin
                input_b_ack = 1'b1;
                if (input_b_stb) state_nxt = ADD_CALC;
            end
            ADD_CALC: state_nxt = ADD_PUT_Z;
            ADD_PUT_Z: begin
                output_z_stb = 1'b1;
                if (output_z_ack) state_nxt = ADD_GET_A;
            end
            default: state_nxt = ADD_GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ADD_GET_A;
            a     <= FP32_ZERO;
            b     <= FP32_ZERO;
            z     <= FP32_ZERO;
        end else begin
            state <= state_nxt;
            if (state == ADD_GET_A && input_a_stb) a <= input_a;
            if (state == ADD_GET_B && input_b_stb) b <= input_b;
            if (state == ADD_CALC) z <= res;
        end
    end

endmodule

// File: rtl/dot_accumulator.sv
// dot_accumulator: folds N_TERMS float32 terms into one sum, strictly left to
// right ((t0+t1)+t2)+..., using the float32 adder instance u_adder.
//
// Handshakes: every stb/ack pair transfers on a rising edge where both are 1;
// the producer holds data stable while stb is high and nothing else is implied.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset (also resets u_adder)
//   input_p, input_p_stb/ack        incoming terms
//   output_z, output_z_stb/ack      one sum per N_TERMS terms
// Parameter: N_TERMS (1..256) terms per result.
// Build option: DOT_ACC_NAN_STICKY_EN -- once a NaN term is seen, the rest of
// the vector bypasses the adder and the result is the canonical NaN.
module dot_accumulator
    import fp32_pkg::*;
#(
    parameter int N_TERMS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_p,
    input  logic        input_p_stb,
    output logic        input_p_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    acc_state_t     state, state_nxt;
    logic [31:0]    sum, term;
    logic [CNT_W-1:0] cnt;
    logic           a_done, b_done;
    logic           in_xfer;

    logic           add_a_stb, add_a_ack, add_b_stb, add_b_ack;
    logic [31:0]    add_z;
    logic           add_z_stb, add_z_ack;

`ifdef DOT_ACC_NAN_STICKY_EN
    logic nan_flag;
    logic skip_add;
    assign skip_add = nan_flag | fp32_isnan(input_p);
`endif

    // ack is held low while rst is asserted so nothing is accepted in reset
    assign in_xfer = input_p_stb & input_p_ack;

    always_comb begin
        state_nxt    = state;
        input_p_ack  = 1'b0;
        output_z_stb = 1'b0;
        output_z     = FP32_ZERO;
        add_a_stb    = 1'b0;
        add_b_stb    = 1'b0;
        add_z_ack    = 1'b0;
        case (state)
            GET_FIRST: begin
                input_p_ack = ~rst;
                if (input_p_stb && !rst) state_nxt = (N_TERMS == 1) ? PUT_Z : GET_NEXT;
            end
            GET_NEXT: begin
                input_p_ack = ~rst;
                if (input_p_stb && !rst) begin
`ifdef DOT_ACC_NAN_STICKY_EN
                    if (skip_add) begin
                        state_nxt = ((cnt + CNT_ONE) == CNT_LAST) ? PUT_Z : GET_NEXT;
                    end else begin
                        state_nxt = ADD_REQ;
                    end
`else
                    state_nxt = ADD_REQ;
`endif
                end
            end
            ADD_REQ: begin
                add_a_stb = ~a_done;
                add_b_stb = ~b_done;
                if ((a_done || add_a_ack) && (b_done || add_b_ack)) state_nxt = ADD_WAIT;
            end
            ADD_WAIT: begin
                add_z_ack = 1'b1;
                if (add_z_stb) state_nxt = (cnt == CNT_LAST) ? PUT_Z : GET_NEXT;
            end
            PUT_Z: begin
                output_z_stb = 1'b1;
`ifdef DOT_ACC_NAN_STICKY_EN
                output_z = nan_flag ? FP32_CANON_NAN : sum;
`else
                output_z = sum;
`endif
                if (output_z_ack) state_nxt = GET_FIRST;
            end
            default: state_nxt = GET_FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= GET_FIRST;
            sum    <= FP32_ZERO;
            term   <= FP32_ZERO;
            cnt    <= '0;
            a_done <= 1'b0;
            b_done <= 1'b0;
`ifdef DOT_ACC_NAN_STICKY_EN
            nan_flag <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                GET_FIRST: begin
                    if (in_xfer) begin
                        sum <= input_p;
                        cnt <= CNT_ONE;
`ifdef DOT_ACC_NAN_STICKY_EN
                        nan_flag <= fp32_isnan(input_p);
`endif
                    end
                end
                GET_NEXT: begin
                    if (in_xfer) begin
                        term   <= input_p;
                        cnt    <= cnt + CNT_ONE;
                        a_done <= 1'b0;
                        b_done <= 1'b0;
`ifdef DOT_ACC_NAN_STICKY_EN
                        nan_flag <= skip_add;
`endif
                    end
                end
                ADD_REQ: begin
                    if (add_a_stb && add_a_ack) a_done <= 1'b1;
                    if (add_b_stb && add_b_ack) b_done <= 1'b1;
                end
                ADD_WAIT: begin
                    if (add_z_stb) sum <= add_z;
                end
                PUT_Z: begin
                    if (output_z_ack) begin
                        cnt <= '0;
`ifdef DOT_ACC_NAN_STICKY_EN
                        nan_flag <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    adder u_adder (
        .clk          (clk),
        .rst          (rst),
        .input_a      (sum),
        .input_a_stb  (add_a_stb),
        .input_a_ack  (add_a_ack),
        .input_b      (term),
        .input_b_stb  (add_b_stb),
        .input_b_ack  (add_b_ack),
        .output_z     (add_z),
        .output_z_stb (add_z_stb),
        .output_z_ack (add_z_ack)
    );

endmodule
